// File: rtl/fir_share_sched_pkg.sv
// Shared constants and helpers for the time-shared 3-tap smoothing filter.
// Latency: n/a (compile-time definitions only).
// Backpressure: n/a.
package fir_share_sched_pkg;

  // Default geometry: two component streams of 8-bit samples
  localparam int DEF_CH = 2;
  localparam int DEF_DW = 8;

  // Tap weights 1/4, 1/2, 1/4 realised as right shifts
  localparam int SHIFT_OUTER  = 2;
  localparam int SHIFT_CENTER = 1;

  // Ceiling log2, never below 1 so a channel tag always has at least one bit
  function automatic int clog2_min1(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first requester after the last winner.
// Latency: grant is combinational; pointer updates at the edge of a granted cycle.
// Backpressure: adv=0 forces an all-zero grant and freezes the pointer.
module rr_arbiter
  import fir_share_sched_pkg::*;
#(
  parameter int CH  = DEF_CH,
  parameter int CHW = clog2_min1(DEF_CH)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [CH-1:0]  req,
  input  logic           adv,
  output logic [CH-1:0]  grant,
  output logic [CHW-1:0] grant_idx,
  output logic           grant_any
);

  logic [CHW-1:0] ptr;
  logic [CHW-1:0] idx;

  // Search from ptr+1 with wrap-around; first requester found wins
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    idx       = '0;
    if (adv) begin
      for (int off = 1; off <= CH; off++) begin
        idx = CHW'((int'(ptr) + off) % CH);
        if (!grant_any && req[idx]) begin
          grant[idx] = 1'b1;
          grant_idx  = idx;
          grant_any  = 1'b1;
        end
      end
    end
  end

  // Pointer remembers the last winner; reset to CH-1 so channel 0 goes first
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= CHW'(CH - 1);
    end else if (grant_any) begin
      ptr <= grant_idx;
    end
  end

endmodule

// File: rtl/fir_share_sched.sv
// Shares one 3-tap (1/4,1/2,1/4) smoothing datapath among CH sample streams, tagged output.
// Latency: handshake in cycle T yields m_valid in cycle T+2; 1 result/cycle aggregate.
// Backpressure: m_valid && !m_ready freezes every stage and drives s_ready to zero.
module fir_share_sched
  import fir_share_sched_pkg::*;
#(
  parameter int CH  = DEF_CH,
  parameter int DW  = DEF_DW,
  parameter int CHW = clog2_min1(CH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [CH-1:0]    s_valid,
  input  logic [CH*DW-1:0] s_data,
  output logic [CH-1:0]    s_ready,
  input  logic [CH-1:0]    clr,
  output logic             m_valid,
  output logic [DW-1:0]    m_data,
  output logic [CHW-1:0]   m_chan,
  input  logic             m_ready
);

  logic           adv;
  logic           hs;
  logic [CHW-1:0] sel;

  logic [DW-1:0]  samp [CH];
  logic [DW-1:0]  h0   [CH];
  logic [DW-1:0]  h1   [CH];

  logic [DW-1:0]  t0;
  logic [DW-1:0]  t1;
  logic [DW-1:0]  t2;
  logic [DW:0]    outer_sum;

  logic           s1_vld;
  logic [CHW-1:0] s1_chan;
  logic [DW-1:0]  p0;
  logic [DW-1:0]  p1;

  // Whole pipeline moves only when the output slot is empty or being drained
  assign adv = !m_valid || m_ready;

  rr_arbiter #(
    .CH  (CH),
    .CHW (CHW)
  ) u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (s_valid),
    .adv       (adv),
    .grant     (s_ready),
    .grant_idx (sel),
    .grant_any (hs)
  );

  // Unpack the flat sample bus and gather taps for the granted channel;
  // a coincident clear makes the sample see an empty history
  always_comb begin
    for (int i = 0; i < CH; i++) begin
      samp[i] = s_data[i*DW +: DW];
    end
    t0        = samp[sel];
    t1        = clr[sel] ? '0 : h0[sel];
    t2        = clr[sel] ? '0 : h1[sel];
    outer_sum = {1'b0, t0} + {1'b0, t2};
  end

  // Per-channel tap history: clear wins over shift, but an accepted sample still lands in h0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < CH; i++) begin
        h0[i] <= '0;
        h1[i] <= '0;
      end
    end else begin
      for (int i = 0; i < CH; i++) begin
        if (clr[i]) begin
          h1[i] <= '0;
          h0[i] <= s_ready[i] ? samp[i] : '0;
        end else if (s_ready[i]) begin
          h1[i] <= h0[i];
          h0[i] <= samp[i];
        end
      end
    end
  end

  // Stage 1: outer taps summed at DW+1 bits then quartered, centre tap halved
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld  <= 1'b0;
      s1_chan <= '0;
      p0      <= '0;
      p1      <= '0;
    end else if (adv) begin
      s1_vld <= hs;
      if (hs) begin
        s1_chan <= sel;
        p0      <= DW'(outer_sum >> SHIFT_OUTER);
        p1      <= t1 >> SHIFT_CENTER;
      end
    end
  end

  // Stage 2: final add; max is (2^DW-1)/2*2 so the DW-bit result never wraps
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid <= 1'b0;
      m_data  <= '0;
      m_chan  <= '0;
    end else if (adv) begin
      m_valid <= s1_vld;
      if (s1_vld) begin
        m_data <= p0 + p1;
        m_chan <= s1_chan;
      end
    end
  end

endmodule

// File: tb/tb_fir_share_sched.sv
// Self-checking bench for fir_share_sched: directed vector table, hand-written
// clear/reset sequences, then randomized traffic against a behavioural model.
module tb_fir_share_sched;

  localparam int CH  = 2;
  localparam int DW  = 8;
  localparam int CHW = 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [CH-1:0]    s_valid = '0;
  logic [CH*DW-1:0] s_data = '0;
  logic [CH-1:0]    s_ready;
  logic [CH-1:0]    clr = '0;
  logic             m_valid;
  logic [DW-1:0]    m_data;
  logic [CHW-1:0]   m_chan;
  logic             m_ready = 1'b1;

  fir_share_sched #(.CH(CH), .DW(DW), .CHW(CHW)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .s_valid (s_valid),
    .s_data  (s_data),
    .s_ready (s_ready),
    .clr     (clr),
    .m_valid (m_valid),
    .m_data  (m_data),
    .m_chan  (m_chan),
    .m_ready (m_ready)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  typedef struct {
    bit         do_rst;
    logic [1:0] sv;
    logic [7:0] d0;
    logic [7:0] d1;
    logic       mr;
    logic [1:0] cl;
    logic [1:0] e_rdy;
    logic       e_mv;
    logic [7:0] e_dat;
    logic       e_ch;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input bit r, input logic [1:0] sv, input int d0, input int d1,
                     input logic mr, input logic [1:0] cl, input logic [1:0] er,
                     input logic emv, input int ed, input int ec);
    vec_t v;
    v.do_rst = r; v.sv = sv; v.d0 = 8'(d0); v.d1 = 8'(d1); v.mr = mr; v.cl = cl;
    v.e_rdy = er; v.e_mv = emv; v.e_dat = 8'(ed); v.e_ch = ec[0];
    tbl.push_back(v);
  endtask

  task automatic apply_reset();
    rst_n   = 1'b0;
    s_valid = '0;
    s_data  = '0;
    clr     = '0;
    m_ready = 1'b1;
    @(posedge clk); #1;
    chk("reset.m_valid", m_valid, 0);
    chk("reset.m_data", m_data, 0);
    chk("reset.m_chan", m_chan, 0);
    rst_n = 1'b1;
  endtask

  // Behavioural reference: spec formula, per-channel histories, last-winner
  // pointer and a two-slot result pipeline that moves only when allowed.
  int h0[CH], h1[CH], last_win;
  bit mv_o, mv_m;
  int md_o, md_m, mc_o, mc_m;

  task automatic model_reset();
    for (int i = 0; i < CH; i++) begin h0[i] = 0; h1[i] = 0; end
    last_win = CH - 1;
    mv_o = 0; mv_m = 0; md_o = 0; md_m = 0; mc_o = 0; mc_m = 0;
  endtask

  task automatic model_step();
    int g, x, t1, t2, res;
    bit adv;
    logic [CH-1:0] er;
    g = -1; x = 0; res = 0; t1 = 0; t2 = 0;
    adv = !mv_o || (m_ready == 1'b1);
    chk("rnd.m_valid", m_valid, mv_o);
    if (mv_o) begin
      chk("rnd.m_data", m_data, md_o);
      chk("rnd.m_chan", m_chan, mc_o);
    end
    if (adv) begin
      for (int k = 1; k <= CH; k++) begin
        int c;
        c = (last_win + k) % CH;
        if (g < 0 && s_valid[c]) g = c;
      end
    end
    er = '0;
    if (g >= 0) er[g] = 1'b1;
    chk("rnd.s_ready", s_ready, er);
    if (g >= 0) begin
      x   = s_data[g*DW +: DW];
      t1  = clr[g] ? 0 : h0[g];
      t2  = clr[g] ? 0 : h1[g];
      res = ((x + t2) / 4 + t1 / 2) % (1 << DW);
    end
    for (int i = 0; i < CH; i++) begin
      if (clr[i]) begin
        h1[i] = 0;
        h0[i] = (i == g) ? x : 0;
      end else if (i == g) begin
        h1[i] = h0[i];
        h0[i] = x;
      end
    end
    if (adv) begin
      mv_o = mv_m; md_o = md_m; mc_o = mc_m;
      mv_m = (g >= 0); md_m = res; mc_m = (g < 0) ? 0 : g;
      if (g >= 0) last_win = g;
    end
  endtask

  int clr_exp[5] = '{10, 30, 40, 10, 30};

  initial begin
    // Group A: ch0 steady 100
    add(1, 2'b01, 100, 0, 1, 2'b00, 2'b01, 0,   0, 0);
    add(0, 2'b01, 100, 0, 1, 2'b00, 2'b01, 0,   0, 0);
    add(0, 2'b01, 100, 0, 1, 2'b00, 2'b01, 1,  25, 0);
    add(0, 2'b01, 100, 0, 1, 2'b00, 2'b01, 1,  75, 0);
    add(0, 2'b01, 100, 0, 1, 2'b00, 2'b01, 1, 100, 0);
    add(0, 2'b00, 100, 0, 1, 2'b00, 2'b00, 1, 100, 0);
    add(0, 2'b00, 100, 0, 1, 2'b00, 2'b00, 1, 100, 0);
    add(0, 2'b00, 100, 0, 1, 2'b00, 2'b00, 0,   0, 0);
    // Group B: both channels, ch0=200 ch1=40, alternate grants
    add(1, 2'b11, 200, 40, 1, 2'b00, 2'b01, 0,   0, 0);
    add(0, 2'b11, 200, 40, 1, 2'b00, 2'b10, 0,   0, 0);
    add(0, 2'b11, 200, 40, 1, 2'b00, 2'b01, 1,  50, 0);
    add(0, 2'b11, 200, 40, 1, 2'b00, 2'b10, 1,  10, 1);
    add(0, 2'b11, 200, 40, 1, 2'b00, 2'b01, 1, 150, 0);
    add(0, 2'b11, 200, 40, 1, 2'b00, 2'b10, 1,  30, 1);
    add(0, 2'b11, 200, 40, 1, 2'b00, 2'b01, 1, 200, 0);
    add(0, 2'b11, 200, 40, 1, 2'b00, 2'b10, 1,  40, 1);
    // Group C: full-scale 255 on ch0
    add(1, 2'b01, 255, 0, 1, 2'b00, 2'b01, 0,   0, 0);
    add(0, 2'b01, 255, 0, 1, 2'b00, 2'b01, 0,   0, 0);
    add(0, 2'b01, 255, 0, 1, 2'b00, 2'b01, 1,  63, 0);
    add(0, 2'b01, 255, 0, 1, 2'b00, 2'b01, 1, 190, 0);
    add(0, 2'b01, 255, 0, 1, 2'b00, 2'b01, 1, 254, 0);
    add(0, 2'b00, 255, 0, 1, 2'b00, 2'b00, 1, 254, 0);
    // Group D: three-cycle stall holds output, blocks input, loses nothing
    add(1, 2'b01,  40, 0, 1, 2'b00, 2'b01, 0,   0, 0);
    add(0, 2'b01,  80, 0, 1, 2'b00, 2'b01, 0,   0, 0);
    add(0, 2'b01, 120, 0, 1, 2'b00, 2'b01, 1,  10, 0);
    add(0, 2'b01, 160, 0, 0, 2'b00, 2'b00, 1,  40, 0);
    add(0, 2'b01, 160, 0, 0, 2'b00, 2'b00, 1,  40, 0);
    add(0, 2'b01, 160, 0, 0, 2'b00, 2'b00, 1,  40, 0);
    add(0, 2'b01, 160, 0, 1, 2'b00, 2'b01, 1,  40, 0);
    add(0, 2'b00,   0, 0, 1, 2'b00, 2'b00, 1,  80, 0);
    add(0, 2'b00,   0, 0, 1, 2'b00, 2'b00, 1, 120, 0);
    add(0, 2'b00,   0, 0, 1, 2'b00, 2'b00, 0,   0, 0);

    #2;
    foreach (tbl[i]) begin
      if (tbl[i].do_rst) apply_reset();
      s_valid = tbl[i].sv;
      s_data  = {tbl[i].d1, tbl[i].d0};
      m_ready = tbl[i].mr;
      clr     = tbl[i].cl;
      @(negedge clk);
      chk($sformatf("vec%0d.s_ready", i), s_ready, tbl[i].e_rdy);
      chk($sformatf("vec%0d.m_valid", i), m_valid, tbl[i].e_mv);
      if (tbl[i].e_mv) begin
        chk($sformatf("vec%0d.m_data", i), m_data, tbl[i].e_dat);
        chk($sformatf("vec%0d.m_chan", i), m_chan, tbl[i].e_ch);
      end
      @(posedge clk); #1;
    end

    // Clear coinciding with a ch1 handshake, then a clear during a stall
    apply_reset();
    s_valid = 2'b10; s_data = {8'd40, 8'd0}; m_ready = 1'b1;
    for (int cyc = 0; cyc < 7; cyc++) begin
      clr = (cyc == 3) ? 2'b10 : 2'b00;
      @(negedge clk);
      if (cyc >= 2) begin
        chk($sformatf("clr%0d.m_valid", cyc), m_valid, 1);
        chk($sformatf("clr%0d.m_data", cyc), m_data, clr_exp[cyc-2]);
        chk($sformatf("clr%0d.m_chan", cyc), m_chan, 1);
      end
      @(posedge clk); #1;
    end
    s_valid = 2'b00; m_ready = 1'b0; clr = 2'b10;
    @(negedge clk);
    chk("clr_stall.m_valid", m_valid, 1);
    chk("clr_stall.s_ready", s_ready, 0);
    @(posedge clk); #1;
    clr = 2'b00; s_valid = 2'b10; m_ready = 1'b1;
    @(posedge clk); #1;
    s_valid = 2'b00;
    @(posedge clk); #1;
    @(negedge clk);
    chk("clr_stall.after_m_valid", m_valid, 1);
    chk("clr_stall.after_m_data", m_data, 10);
    @(posedge clk); #1;

    // Reset asserted with results in flight
    apply_reset();
    s_valid = 2'b01; s_data = {8'd0, 8'd100}; m_ready = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    chk("midrst.pre_m_valid", m_valid, 1);
    rst_n = 1'b0;
    #1;
    chk("midrst.async_m_valid", m_valid, 0);
    chk("midrst.async_m_data", m_data, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int cyc = 0; cyc < 3; cyc++) begin
      @(negedge clk);
      chk($sformatf("midrst%0d.m_valid", cyc), m_valid, (cyc == 2) ? 1 : 0);
      if (cyc == 2) chk("midrst.first_m_data", m_data, 25);
      @(posedge clk); #1;
    end

    // Randomized traffic against the reference model
    apply_reset();
    model_reset();
    for (int n = 0; n < 800; n++) begin
      s_valid = CH'($urandom);
      s_data  = (CH*DW)'($urandom);
      m_ready = ($urandom_range(0, 3) != 0);
      clr     = ($urandom_range(0, 15) == 0) ? CH'($urandom) : '0;
      @(negedge clk);
      model_step();
      @(posedge clk); #1;
    end
    s_valid = '0; clr = '0; m_ready = 1'b1;
    repeat (4) begin
      @(negedge clk);
      model_step();
      @(posedge clk); #1;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fir_share_sched.md
Name: fir_share_sched

Overview:
Scheduler that time-shares one 3-tap low-pass smoothing datapath (weights 1/4, 1/2, 1/4) among CH independent 8-bit sample streams, for example luma and chroma.
- Round-robin arbitration selects at most one stream per cycle.
- Per-channel tap history is kept inside the block.
- The selected sample passes through a 2-stage arithmetic pipeline.
- Results go to a single valid/ready output tagged with the channel index.
- Sits between the per-component pixel sources and the downstream formatter. It replaces one dedicated filter instance per component.

Parameters:
CH, 2, number of requesting channels (2..8)
DW, 8, sample width in bits
CHW, 1, channel-index width (clog2(CH), minimum 1)

Ports:
clk  input  1  clock
rst_n  input  1  reset, asynchronous, active-low
s_valid  input  CH  per-channel sample valid
s_data  input  CH*DW  per-channel samples; channel i occupies bits [i*DW +: DW]
s_ready  output  CH  per-channel accept (one-hot or zero)
clr  input  CH  per-channel synchronous history clear
m_valid  output  1  filtered result valid
m_data  output  DW  filtered result
m_chan  output  CHW  channel index of m_data
m_ready  input  1  downstream accept

Behaviour:
- Reset is asynchronous, active-low, on rst_n; clock is clk.
- Values during and after reset:
  - m_valid=0, m_data=0, m_chan=0.
  - All history registers = 0.
  - Pipeline valid bits = 0.
  - RR pointer = CH-1, so channel 0 has first priority.
- Advance enable: adv = !m_valid || m_ready. When adv=0, every register holds and s_ready=0.
- Arbitration:
  - When adv=1, grant the first channel with s_valid=1, searching from pointer+1 with wrap-around.
  - s_ready = one-hot grant (combinational from s_valid, pointer and adv). A handshake occurs when s_valid[i] && s_ready[i].
  - On a handshake the pointer becomes the granted index. With no request the pointer is unchanged.
- Per-channel history: h0[i] (previous sample) and h1[i] (sample before that).
- On a handshake on channel i with sample x:
  - Taps are t0=x, t1=h0[i], t2=h1[i].
  - History updates h1[i]<=h0[i], h0[i]<=x.
- Stage 1 (registered, on adv):
  - p0 = (t0+t2)>>2, with the sum computed at DW+1 bits before the shift.
  - p1 = t1>>1.
  - The stage valid bit and channel tag are also registered.
- Stage 2 (on adv): m_data <= p0+p1, truncated to DW bits. The result never exceeds 2^DW-2, so truncation is lossless. m_chan and m_valid are registered from stage 1.
- Latency: handshake in cycle T gives m_valid in cycle T+2, provided there is no stall. Throughput is 1 result per cycle across all channels.
- A bubble (no handshake) propagates as an invalid stage. m_valid drops after m_ready consumes the last result.
- Clear:
  - clr[i] zeroes h0[i] and h1[i] at the next edge.
  - If clr[i] coincides with a handshake on channel i, the sample is filtered with t1=t2=0. History then becomes h0=x, h1=0.
  - clr is honoured even when adv=0.
- Reset asserted mid-operation discards in-flight results. No partial output is produced.
- Channels are never starved: with all requesters valid, each channel is granted at least once every CH accepting cycles.

Decomposition:
- Shared package holds:
  - default CH and DW
  - tap shift constants SHIFT_OUTER=2 and SHIFT_CENTER=1
  - a clog2 function used to derive CHW
- One sub-module: rr_arbiter (CH-wide request, adv, one-hot grant, registered pointer).
- The history array and the 2-stage arithmetic stay in fir_share_sched.

Test Plan:
- Channel 0 only, steady 100, m_ready=1 → m_data 25, 75, 100, 100…, m_chan=0. Each result appears 2 cycles after its handshake.
- Both channels valid continuously, ch0=200, ch1=40 → grants alternate 0,1,0,1.
  - ch0 results are 50, 150, 200.
  - ch1 results are 10, 30, 40.
  - m_chan alternates 0,1.
- Stream 255 on ch0 → results 63, 190, 254. This checks the DW+1 sum width and the absence of overflow.
- m_ready=0 for 3 cycles with m_valid=1 → m_data and m_chan are stable and s_ready=0. The sequence resumes with no loss or duplication.
- ch1 steady 40, then clr[1] together with a handshake → that result is 10 and the next is 30.
- rst_n pulsed low while results are in flight → m_valid goes to 0 immediately and history is zeroed. The first ch0 sample 100 after release gives 25.
